// File: rtl/in_reg_capture_ctrl.sv
// Sequences clear/preset/capture strobes for a bank of input-register cells and
// streams the captured pad values back out as paced valid/ready samples.
module in_reg_capture_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 8,
  parameter int DIV_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [NUM_LANES-1:0] cmd_mask,
  input  logic [CNT_W-1:0]     cmd_count,
  input  logic [DIV_W-1:0]     cmd_div,
  output logic [NUM_LANES-1:0] reg_sel,
  output logic [NUM_LANES-1:0] reg_rst,
  output logic [NUM_LANES-1:0] reg_hold,
  input  logic [NUM_LANES-1:0] reg_q,
  output logic                 smp_valid,
  input  logic                 smp_ready,
  output logic [NUM_LANES-1:0] smp_data,
  output logic                 smp_last,
  output logic                 busy,
  output logic                 done
);

  // state  | meaning
  // IDLE   | ready for a command; also the done cycle of a no-strobe command
  // STROBE | reg_rst or reg_hold driven for one cycle, done pulses
  // SEL    | reg_sel driven, input registers capture at the end of this cycle
  // LATCH  | register output settles; sample taken at the end of this cycle
  // WAIT   | divider countdown and backpressure stall before the next SEL
  // DRAIN  | last sample waiting for its handshake
  typedef enum logic [2:0] {IDLE, STROBE, SEL, LATCH, WAIT, DRAIN} state_e;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_CLEAR   = 2'b01;
  localparam logic [1:0] OP_PRESET  = 2'b10;
  localparam logic [1:0] OP_CAPTURE = 2'b11;

  state_e               state_q;
  logic [NUM_LANES-1:0] mask_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     idx_q;
  logic [DIV_W-1:0]     div_cfg_q;
  logic [DIV_W-1:0]     div_q;
  logic                 cmd_ready_q;
  logic [NUM_LANES-1:0] reg_sel_q;
  logic [NUM_LANES-1:0] reg_rst_q;
  logic [NUM_LANES-1:0] reg_hold_q;
  logic                 smp_valid_q;
  logic [NUM_LANES-1:0] smp_data_q;
  logic                 smp_last_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 smp_take_d;
  logic                 is_last_d;
  logic                 no_strobe_d;

  assign smp_take_d  = smp_valid_q && smp_ready;
  assign is_last_d   = (idx_q == cnt_q - CNT_W'(1));
  assign no_strobe_d = (cmd_op == OP_NOP) || (cmd_mask == '0) ||
                       ((cmd_op == OP_CAPTURE) && (cmd_count == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      div_cfg_q   <= '0;
      div_q       <= '0;
      cmd_ready_q <= 1'b0;
      reg_sel_q   <= '0;
      reg_rst_q   <= '0;
      reg_hold_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      smp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      reg_sel_q  <= '0;
      reg_rst_q  <= '0;
      reg_hold_q <= '0;
      if (smp_take_d) begin
        smp_valid_q <= 1'b0;
        smp_last_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && cmd_valid) begin
            cmd_ready_q <= 1'b0;
            mask_q      <= cmd_mask;
            cnt_q       <= cmd_count;
            div_cfg_q   <= cmd_div;
            idx_q       <= '0;
            if (no_strobe_d) begin
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              case (cmd_op)
                OP_CLEAR: begin
                  reg_rst_q <= cmd_mask;
                  done_q    <= 1'b1;
                  state_q   <= STROBE;
                end
                OP_PRESET: begin
                  reg_hold_q <= cmd_mask;
                  done_q     <= 1'b1;
                  state_q    <= STROBE;
                end
                default: begin
                  reg_sel_q <= cmd_mask;
                  state_q   <= SEL;
                end
              endcase
            end
          end
        end

        STROBE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end

        SEL: state_q <= LATCH;

        LATCH: begin
          smp_data_q  <= reg_q & mask_q;
          smp_valid_q <= 1'b1;
          smp_last_q  <= is_last_d;
          div_q       <= div_cfg_q;
          if (is_last_d) begin
            state_q <= DRAIN;
          end else begin
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= WAIT;
          end
        end

        // a sample consumed on this same edge frees the slot for the next SEL
        WAIT: begin
          if (div_q != '0) begin
            div_q <= div_q - DIV_W'(1);
          end else if (!smp_valid_q || smp_ready) begin
            reg_sel_q <= mask_q;
            state_q   <= SEL;
          end
        end

        DRAIN: begin
          if (smp_take_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign reg_sel   = reg_sel_q;
  assign reg_rst   = reg_rst_q;
  assign reg_hold  = reg_hold_q;
  assign smp_valid = smp_valid_q;
  assign smp_data  = smp_data_q;
  assign smp_last  = smp_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
